// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if - byte handshake and status bundle of the UART receiver.
//   rx_data   : received byte (receiver -> consumer)
//   rx_valid  : rx_data holds an unacknowledged byte
//   rx_ack    : consumer accepts rx_data (consumer -> receiver)
//   frame_err : one-cycle pulse, stop bit sampled low
//   overrun   : one-cycle pulse, unacknowledged byte overwritten
//   busy      : receiver is inside a frame (or waiting out a break)
// Modports: master = receiver side, slave = consumer side.
// ---------------------------------------------------------------------------
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ack;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        output rx_data, rx_valid, frame_err, overrun, busy,
        input  rx_ack
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, overrun, busy,
        output rx_ack
    );
endinterface

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx - 8N1-style UART receiver with valid/ack byte handoff.
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   UART_RXD : asynchronous serial line, idle high
//   bus      : uart_rx_if.master (rx_data, rx_valid, rx_ack, frame_err,
//              overrun, busy)
// The line is double-flopped into rxd_s; the FSM samples mid-bit by
// counting half a bit after the start edge, then whole bits from there.
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       UART_RXD,
    uart_rx_if.master  bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic                 rxd_p0;
    logic                 rxd_s;
    logic [2:0]           state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 ovr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_p0  <= 1'b1;
            rxd_s   <= 1'b1;
            state   <= S_IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            // synchroniser stages
            rxd_p0 <= UART_RXD;
            rxd_s  <= rxd_p0;

            // frame decode
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;

            // Ack clears valid; a delivery later in this block overrides it,
            // which gives "ack and new byte on the same edge -> valid stays 1".
            if (valid_q && bus.rx_ack)
                valid_q <= 1'b0;

            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!rxd_s)
                        state <= S_START;
                end
                S_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rxd_s) begin
                            state <= S_DATA;
                            idx   <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
                        idx   <= idx + 1'b1;
                        if (idx == IDX_LAST)
                            state <= S_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rxd_s) begin
                            data_q  <= shreg;
                            valid_q <= 1'b1;
                            ovr_q   <= valid_q && !bus.rx_ack;
                            state   <= S_IDLE;
                        end else begin
                            ferr_q <= 1'b1;
                            state  <= S_BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    // Hold here while the line is low so a break cannot
                    // be mistaken for a stream of start bits.
                    cnt <= '0;
                    if (rxd_s)
                        state <= S_IDLE;
                end
                default: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;
    assign bus.busy      = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx - directed bench for uart_rx at CLKS_PER_BIT=16, DATA_BITS=8.
// Inputs are driven just after the falling edge, outputs sampled on it.
// ---------------------------------------------------------------------------
module tb_uart_rx;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd_line = 1'b1;

    uart_rx_if #(.DATA_BITS(8)) bus ();

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .UART_RXD (rxd_line),
        .bus      (bus.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t_start  = 0;
    int t_valid  = 0;
    int rises    = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    int both_cnt = 0;
    logic prev_valid = 1'b0;
    logic [7:0] got [2];

    always @(posedge clk) cyc++;

    // event monitor: valid rises, pulse cycles, pulse collisions
    always @(negedge clk) begin
        if (bus.rx_valid && !prev_valid) begin
            rises++;
            t_valid = cyc;
        end
        prev_valid = bus.rx_valid;
        if (bus.frame_err) fe_cnt++;
        if (bus.overrun)   ov_cnt++;
        if (bus.frame_err && bus.overrun) both_cnt++;
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // start bit, LSB-first data, then stop level held for stop_len cycles
    task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_len);
        rxd_line = 1'b0;
        t_start  = cyc;
        wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd_line = b[i];
            wait_cyc(CPB);
        end
        rxd_line = stop;
        wait_cyc(stop_len);
    endtask

    task automatic ack_pulse();
        bus.rx_ack = 1'b1;
        @(negedge clk);
        bus.rx_ack = 1'b0;
    endtask

    int r0, f0, o0;

    initial begin
        bus.rx_ack = 1'b0;
        wait_cyc(3);
        rst = 1'b0;
        chk_eq("rst_data",  bus.rx_data,   8'h00);
        chk_eq("rst_valid", bus.rx_valid,  1'b0);
        chk_eq("rst_ferr",  bus.frame_err, 1'b0);
        chk_eq("rst_ovr",   bus.overrun,   1'b0);
        chk_eq("rst_busy",  bus.busy,      1'b0);
        wait_cyc(5);

        // single byte 0xA5
        r0 = rises;
        send_frame(8'hA5, 1'b1, CPB);
        chk_eq("a5_rises", rises - r0, 1);
        chk_eq("a5_latency_ok", ((t_valid - t_start) >= 153 && (t_valid - t_start) <= 157), 1'b1);
        chk_eq("a5_data", bus.rx_data, 8'hA5);
        chk_eq("a5_valid", bus.rx_valid, 1'b1);
        ack_pulse();
        chk_eq("a5_ack_clears", bus.rx_valid, 1'b0);
        wait_cyc(4);

        // glitch: 5 cycles low
        r0 = rises; f0 = fe_cnt;
        rxd_line = 1'b0;
        wait_cyc(4);
        chk_eq("glitch_busy_hi", bus.busy, 1'b1);
        wait_cyc(1);
        rxd_line = 1'b1;
        wait_cyc(20);
        chk_eq("glitch_busy_lo", bus.busy, 1'b0);
        chk_eq("glitch_no_valid", rises - r0, 0);
        chk_eq("glitch_no_ferr", fe_cnt - f0, 0);
        send_frame(8'h3C, 1'b1, CPB);
        chk_eq("3c_data", bus.rx_data, 8'h3C);
        chk_eq("3c_valid", bus.rx_valid, 1'b1);
        ack_pulse();
        wait_cyc(4);

        // framing error: 0x55, stop low, line low 40 cycles in total
        r0 = rises; f0 = fe_cnt;
        send_frame(8'h55, 1'b0, 40);
        chk_eq("fe_pulse_cycles", fe_cnt - f0, 1);
        chk_eq("fe_no_valid", bus.rx_valid, 1'b0);
        chk_eq("fe_no_rise", rises - r0, 0);
        chk_eq("fe_busy_break", bus.busy, 1'b1);
        rxd_line = 1'b1;
        wait_cyc(5);
        chk_eq("fe_busy_release", bus.busy, 1'b0);
        send_frame(8'h81, 1'b1, CPB);
        chk_eq("81_data", bus.rx_data, 8'h81);
        chk_eq("81_valid", bus.rx_valid, 1'b1);
        ack_pulse();
        wait_cyc(4);

        // back-to-back 0x00 then 0xFF with ack on each byte
        o0 = ov_cnt;
        fork
            begin
                send_frame(8'h00, 1'b1, CPB);
                send_frame(8'hFF, 1'b1, CPB);
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    int w;
                    w = 0;
                    while (!bus.rx_valid && w < 400) begin
                        @(negedge clk);
                        w++;
                    end
                    chk_eq("b2b_wait_in_time", (w < 400), 1'b1);
                    got[k] = bus.rx_data;
                    ack_pulse();
                end
            end
        join
        chk_eq("b2b_first", got[0], 8'h00);
        chk_eq("b2b_second", got[1], 8'hFF);
        chk_eq("b2b_no_ovr", ov_cnt - o0, 0);
        wait_cyc(4);

        // overrun: 0x12 then 0x34, no ack
        o0 = ov_cnt;
        send_frame(8'h12, 1'b1, CPB);
        send_frame(8'h34, 1'b1, CPB);
        chk_eq("ovr_pulse", ov_cnt - o0, 1);
        chk_eq("ovr_data", bus.rx_data, 8'h34);
        chk_eq("ovr_valid", bus.rx_valid, 1'b1);
        ack_pulse();
        wait_cyc(4);

        // same, but ack lands on the 0x34 delivery edge (start drive + 155)
        o0 = ov_cnt;
        send_frame(8'h12, 1'b1, CPB);
        fork
            send_frame(8'h34, 1'b1, CPB);
            begin
                @(negedge clk);
                while (cyc < t_start + 154) @(negedge clk);
                ack_pulse();
            end
        join
        chk_eq("ack_same_edge_no_ovr", ov_cnt - o0, 0);
        chk_eq("ack_same_edge_data", bus.rx_data, 8'h34);
        chk_eq("ack_same_edge_valid", bus.rx_valid, 1'b1);

        // reset during data bit 3 (0x34 left pending so reset must clear it)
        rxd_line = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 3; i++) begin
            rxd_line = i[0];
            wait_cyc(CPB);
        end
        rxd_line = 1'b1;
        wait_cyc(8);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_eq("mid_rst_data",  bus.rx_data,   8'h00);
        chk_eq("mid_rst_valid", bus.rx_valid,  1'b0);
        chk_eq("mid_rst_ferr",  bus.frame_err, 1'b0);
        chk_eq("mid_rst_ovr",   bus.overrun,   1'b0);
        chk_eq("mid_rst_busy",  bus.busy,      1'b0);
        wait_cyc(20);
        r0 = rises; f0 = fe_cnt; o0 = ov_cnt;
        send_frame(8'h7E, 1'b1, CPB);
        chk_eq("7e_data", bus.rx_data, 8'h7E);
        chk_eq("7e_valid", bus.rx_valid, 1'b1);
        chk_eq("7e_one_rise", rises - r0, 1);
        chk_eq("7e_no_ferr", fe_cnt - f0, 0);
        chk_eq("7e_no_ovr", ov_cnt - o0, 0);
        wait_cyc(4);

        chk_eq("ferr_ovr_never_together", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: 8N1 serial line in, parallel byte out through a valid/ack handshake.
- Counterpart of the transmitter driving UART_TXD at top level.
- Takes host-to-board bytes, e.g. mux test vectors or switch overrides, and hands them to top-level control logic.
- Line input is asynchronous; everything else runs on the single system clock.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per bit (100 MHz / 115200 baud); must be >= 4.
- DATA_BITS, 8, data bits per frame, LSB first; legal range 5..8.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- UART_RXD  input  1  asynchronous serial line, idle high.
- rx_data  output  DATA_BITS  last correctly framed byte.
- rx_valid  output  1  rx_data holds an unacknowledged byte.
- rx_ack  input  1  consumer accepts rx_data; only meaningful while rx_valid=1.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- overrun  output  1  one-cycle pulse when a new byte overwrites an unacknowledged one.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Synchroniser: UART_RXD passes through 2 flops to give rxd_s; the flops reset to 1. All decisions use rxd_s only.
- Reset: on rst=1 at a clk edge, all of the following are cleared:
  - outputs: rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0;
  - internal: state=IDLE, baud counter=0, bit index=0, shift register=0.
- Reset mid-frame aborts the frame with no output.
- Baud counter width is $clog2(CLKS_PER_BIT). It is reset to 0 on every state entry.
- FSM states:
  - IDLE: stay while rxd_s=1; on rxd_s=0 go to START.
  - START: count to CLKS_PER_BIT/2-1 (integer division). At that count:
    - rxd_s=0: go to DATA with bit index=0.
    - rxd_s=1: treat as a glitch and return to IDLE; no output pulse.
  - DATA: count to CLKS_PER_BIT-1, then shift rxd_s into the MSB of the shift register (right shift, so LSB-first arrival) and increment the bit index. After DATA_BITS samples go to STOP.
  - STOP: count to CLKS_PER_BIT-1, then sample rxd_s:
    - rxd_s=1: load rx_data from the shift register, set rx_valid=1, go to IDLE. The return at mid-stop-bit allows resync to a following start bit.
    - rxd_s=0: pulse frame_err, discard the data (rx_data and rx_valid unchanged), go to BREAK.
  - BREAK: stay until rxd_s=1, then go to IDLE. This prevents a held-low line from retriggering START.
- Latency: rx_valid and frame_err rise on the edge after the stop-sample edge. From the falling edge at the pin, that is ~2 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT cycles.
- Handshake:
  - rx_valid is held until an edge where rx_ack=1, then clears on that edge.
  - rx_data is stable while rx_valid=1, except on overrun.
  - rx_ack while rx_valid=0 is ignored.
- Simultaneous ack and new byte on the same edge: rx_valid stays 1 and rx_data takes the new byte. No overrun.
- Overrun: a new byte is delivered while rx_valid=1 and rx_ack=0. Then rx_data is overwritten, rx_valid stays 1, and overrun pulses for 1 cycle.
- frame_err and overrun are never high in the same cycle.
- busy=1 in START, DATA, STOP and BREAK.

Test Plan:
All scenarios use CLKS_PER_BIT=16 and DATA_BITS=8; the bench drives UART_RXD bit-accurately.
- Single byte 0xA5 (line 0,1,0,1,0,0,1,0,1,1 = start, data LSB first, stop) -> rx_valid rises ~2+8+144 cycles after the start edge, rx_data=0xA5. rx_ack pulse -> rx_valid=0 on the next edge.
- Glitch: UART_RXD low for 5 cycles, then high -> FSM returns to IDLE, busy drops, no rx_valid/frame_err. A following frame 0x3C is received correctly.
- Framing error: send 0x55 with the stop bit 0 and hold the line low 40 cycles, then high -> frame_err is a single 1-cycle pulse, rx_valid stays 0, busy stays 1 until the line goes high. A next frame 0x81 is received OK.
- Back-to-back frames 0x00 then 0xFF (no idle gap), rx_ack pulsed on each rx_valid -> both bytes delivered in order, no overrun.
- Overrun: send 0x12 and 0x34 with no ack -> overrun pulses once, rx_data=0x34, rx_valid=1. Repeat with rx_ack asserted exactly on the 0x34 delivery edge -> no overrun, rx_data=0x34, rx_valid=1.
- Reset mid-frame: assert rst for 1 cycle during data bit 3 -> all outputs 0, busy=0. With the line held high, the next full frame 0x7E is received correctly with no spurious pulse.
